// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//
// Shares one SDRAM controller port between NUM_CLIENTS toggle-handshake
// requesters (client 0 = PRG fetch, 1 = CHR fetch, 2 = MCU loader).
// Client 0 has absolute priority. Clients 1..NUM_CLIENTS-1 are served
// round-robin. Each client's last read word is held until that client's
// next completed read.
//
// Handshake (both the client side and the controller side):
//   The requester sets its command fields and then toggles req. The request
//   is outstanding while req != ack. The fields stay stable until ack == req.
//   The responder completes the request by toggling ack so that it equals req
//   again. Only inequality is evaluated, so a double toggle cancels an
//   unserved request.
//
// Ports
//   clk, reset_n      system clock, asynchronous active-low reset
//   c_req / c_ack     per-client request / completion toggles
//   c_we              per-client write enable (1 = write)
//   c_address         per-client word address, client i at [i*ADDR_BITS +: ADDR_BITS]
//   c_data_write      per-client write data, client i at [i*16 +: 16]
//   c_wmask           per-client byte enables, bit1 = [15:8], bit0 = [7:0]
//   c_data_read       per-client registered read data, client i at [i*16 +: 16]
//   m_req / m_ack     controller request / completion toggles
//   m_we, m_address,
//   m_data_write,
//   m_wmask           registered command to the controller
//   m_data_read       controller read data, valid when m_ack == m_req
//   busy              1 while a command is outstanding at the controller
//   grant             index of the client currently or last served
//   fsm_state         debug view of the FSM: 0 = IDLE, 1 = BUSY
// ---------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int  NUM_CLIENTS = 3,
    parameter int  ADDR_BITS   = 22,
    localparam int GW          = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_CLIENTS-1:0]           c_req,
    output logic [NUM_CLIENTS-1:0]           c_ack,
    input  logic [NUM_CLIENTS-1:0]           c_we,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0] c_address,
    input  logic [NUM_CLIENTS*16-1:0]        c_data_write,
    input  logic [NUM_CLIENTS*2-1:0]         c_wmask,
    output logic [NUM_CLIENTS*16-1:0]        c_data_read,
    output logic                             m_req,
    input  logic                             m_ack,
    output logic                             m_we,
    output logic [ADDR_BITS-1:0]             m_address,
    output logic [15:0]                      m_data_write,
    output logic [1:0]                       m_wmask,
    input  logic [15:0]                      m_data_read,
    output logic                             busy,
    output logic [GW-1:0]                    grant,
    output logic                             fsm_state
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;

    logic [NUM_CLIENTS-1:0] pending;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          win;
    logic [GW-1:0]          rr_next;
    logic [GW:0]            cand;
    logic [GW:0]            win_inc;
    logic                   found;

    logic [ADDR_BITS-1:0] addr_arr  [NUM_CLIENTS];
    logic [15:0]          wdata_arr [NUM_CLIENTS];
    logic [1:0]           wmask_arr [NUM_CLIENTS];
    logic [15:0]          rd_q      [NUM_CLIENTS];

    // Unpack the flat client buses and pack the held read words back out.
    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_clients
        assign addr_arr[g]             = c_address[g*ADDR_BITS +: ADDR_BITS];
        assign wdata_arr[g]            = c_data_write[g*16 +: 16];
        assign wmask_arr[g]            = c_wmask[g*2 +: 2];
        assign c_data_read[g*16 +: 16] = rd_q[g];
    end

    assign pending   = c_req ^ c_ack;
    assign fsm_state = (state == BUSY);

    // Winner: client 0 if pending, else the first pending client found by
    // walking 1..NUM_CLIENTS-1 starting at rr_ptr and wrapping back to 1.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        if (pending[0]) begin
            found = 1'b1;
        end
        for (int k = 0; k < NUM_CLIENTS - 1; k++) begin
            cand = {1'b0, rr_ptr} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_CLIENTS)) begin
                cand = cand - (GW+1)'(NUM_CLIENTS - 1);
            end
            if (!found && pending[cand[GW-1:0]]) begin
                win   = cand[GW-1:0];
                found = 1'b1;
            end
        end
    end

    // Pointer value after granting client win (only used when win >= 1).
    always_comb begin
        win_inc = {1'b0, win} + (GW+1)'(1);
        rr_next = win_inc[GW-1:0];
        if (win_inc == (GW+1)'(NUM_CLIENTS)) begin
            rr_next = GW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_address    <= '0;
            m_data_write <= '0;
            m_wmask      <= '0;
            c_ack        <= '0;
            busy         <= 1'b0;
            grant        <= '0;
            rr_ptr       <= GW'(1);
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        m_we         <= c_we[win];
                        m_address    <= addr_arr[win];
                        m_data_write <= wdata_arr[win];
                        m_wmask      <= wmask_arr[win];
                        m_req        <= ~m_req;
                        grant        <= win;
                        busy         <= 1'b1;
                        state        <= BUSY;
                        // A grant to client 0 must not disturb the rotation.
                        if (win != '0) begin
                            rr_ptr <= rr_next;
                        end
                    end
                end
                BUSY: begin
                    if (m_ack == m_req) begin
                        if (!m_we) begin
                            rd_q[grant] <= m_data_read;
                        end
                        c_ack[grant] <= ~c_ack[grant];
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Drives three toggle-handshake clients into sdram_arbiter and plays the
// SDRAM controller with a small word memory. Expected grant order is queued
// when requests are posted and popped when the arbiter issues m_req.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int NC = 3;
    localparam int AB = 22;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- DUT signals ----------------
    logic [NC-1:0]    c_req = '0;
    logic [NC-1:0]    c_ack;
    logic [NC-1:0]    c_we = '0;
    logic [NC*AB-1:0] c_address = '0;
    logic [NC*16-1:0] c_data_write = '0;
    logic [NC*2-1:0]  c_wmask = '0;
    logic [NC*16-1:0] c_data_read;
    logic             m_req;
    logic             m_ack = 1'b0;
    logic             m_we;
    logic [AB-1:0]    m_address;
    logic [15:0]      m_data_write;
    logic [1:0]       m_wmask;
    logic [15:0]      m_data_read = '0;
    logic             busy;
    logic [1:0]       grant;
    logic             fsm_state;

    sdram_arbiter #(.NUM_CLIENTS(NC), .ADDR_BITS(AB)) dut (
        .clk(clk), .reset_n(reset_n),
        .c_req(c_req), .c_ack(c_ack), .c_we(c_we), .c_address(c_address),
        .c_data_write(c_data_write), .c_wmask(c_wmask), .c_data_read(c_data_read),
        .m_req(m_req), .m_ack(m_ack), .m_we(m_we), .m_address(m_address),
        .m_data_write(m_data_write), .m_wmask(m_wmask), .m_data_read(m_data_read),
        .busy(busy), .grant(grant), .fsm_state(fsm_state)
    );

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- bench state ----------------
    logic [1:0]  exp_q[$];             // expected grant order
    logic        req_we   [NC];
    logic [21:0] req_addr [NC];
    logic [15:0] req_data [NC];
    logic [1:0]  req_mask [NC];
    int          req_cyc  [NC];
    logic [15:0] exp_rd   [NC];
    bit   [15:0] mem [int];

    int ctl_fixed  = 5;                // 0 = random controller latency
    int exp_lat    = 0;                // 0 = no end-to-end latency check
    int gap_on     = 0;
    int gap_base   = 0;
    int acks_seen  = 0;
    int grants_seen = 0;

    function automatic logic [15:0] mem_rd(input logic [21:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Post one request for client i: set fields, then toggle c_req[i].
    task automatic post(input int i, input logic we, input logic [21:0] a,
                        input logic [15:0] d, input logic [1:0] m);
        req_we[i]   = we;
        req_addr[i] = a;
        req_data[i] = d;
        req_mask[i] = m;
        req_cyc[i]  = cyc;
        c_we[i]                = we;
        c_address[i*AB +: AB]  = a;
        c_data_write[i*16 +: 16] = d;
        c_wmask[i*2 +: 2]      = m;
        c_req[i]               = ~c_req[i];
    endtask

    task automatic wait_done(input int budget);
        int  n = 0;
        logic done = 1'b0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
            done = (c_req == c_ack) && !busy && (exp_q.size() == 0);
        end
        check("wait_done", {63'd0, done}, 64'd1);
        @(negedge clk); #1;
    endtask

    // ---------------- controller model ----------------
    initial begin
        bit active = 0;
        int cnt = 0;
        int lat = 5;
        logic [15:0] old;
        forever begin
            @(posedge clk or negedge reset_n); #1;
            if (!reset_n) begin
                m_ack  = 1'b0;
                active = 0;
            end else if (!active && (m_req != m_ack)) begin
                active = 1;
                cnt    = 0;
                lat    = (ctl_fixed != 0) ? ctl_fixed : $urandom_range(1, 6);
            end else if (active) begin
                cnt++;
                if (cnt == lat) begin
                    if (m_we) begin
                        old = mem_rd(m_address);
                        mem[int'(m_address)] = {m_wmask[1] ? m_data_write[15:8] : old[15:8],
                                                m_wmask[0] ? m_data_write[7:0]  : old[7:0]};
                        m_data_read = 16'hDEAD;   // garbage that must not be captured
                    end else begin
                        m_data_read = mem_rd(m_address);
                    end
                    m_ack  = m_req;
                    active = 0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic          prev_mreq = 1'b0;
        logic [NC-1:0] prev_cack = '0;
        logic [1:0]    cur = '0;
        logic          cur_we = 1'b0;
        logic [15:0]   cur_rdata = '0;
        logic          in_flight = 1'b0;
        int            last_ack_cyc = 0;
        for (int i = 0; i < NC; i++) exp_rd[i] = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_mreq = m_req;
                prev_cack = c_ack;
                in_flight = 1'b0;
                exp_q.delete();
                for (int i = 0; i < NC; i++) exp_rd[i] = '0;
            end else begin
                if (m_req != prev_mreq) begin
                    grants_seen++;
                    in_flight = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", 64'(grant), 64'hFF);
                    end else begin
                        cur = exp_q.pop_front();
                        check("grant", 64'(grant), 64'(cur));
                        check("m_we", 64'(m_we), 64'(req_we[cur]));
                        check("m_address", 64'(m_address), 64'(req_addr[cur]));
                        check("m_data_write", 64'(m_data_write), 64'(req_data[cur]));
                        check("m_wmask", 64'(m_wmask), 64'(req_mask[cur]));
                        cur_we    = req_we[cur];
                        cur_rdata = mem_rd(req_addr[cur]);
                        if (gap_on != 0 && grants_seen > gap_base + 1)
                            check("gap", 64'(cyc - last_ack_cyc), 64'd1);
                    end
                end
                for (int i = 0; i < NC; i++) begin
                    if (c_ack[i] != prev_cack[i]) begin
                        check("ack_client", 64'(i), 64'(cur));
                        if (exp_lat != 0)
                            check("ack_latency", 64'(cyc - req_cyc[i]), 64'(exp_lat));
                        if (!cur_we) exp_rd[cur] = cur_rdata;
                        last_ack_cyc = cyc;
                        in_flight    = 1'b0;
                        acks_seen++;
                    end
                end
                check("busy", 64'(busy), 64'(in_flight));
                check("fsm_state", 64'(fsm_state), 64'(in_flight));
                check("c_data_read", 64'(c_data_read), 64'({exp_rd[2], exp_rd[1], exp_rd[0]}));
                prev_mreq = m_req;
                prev_cack = c_ack;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int   n1, n2, base;
        bit   injected;
        logic seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_req", 64'(m_req), 64'd0);
        check("rst_c_ack", 64'(c_ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_c_data_read", 64'(c_data_read), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single read, client 1, fixed 5-cycle controller
        mem[int'(22'h00123)] = 16'hBEEF;
        exp_lat = 7;
        exp_q.push_back(2'd1);
        post(1, 1'b0, 22'h00123, 16'h0000, 2'b11);
        wait_done(40);
        exp_lat = 0;
        check("t1_rd1", 64'(c_data_read[31:16]), 64'hBEEF);
        check("t1_rd_others", 64'({c_data_read[47:32], c_data_read[15:0]}), 64'd0);

        // Masked write, client 2, top address
        @(posedge clk); #1;
        exp_q.push_back(2'd2);
        post(2, 1'b1, 22'h3FFFFF, 16'h5A00, 2'b10);
        wait_done(40);
        check("t2_rd2", 64'(c_data_read[47:32]), 64'd0);
        check("t2_mem", 64'(mem_rd(22'h3FFFFF)), 64'({8'h5A, 8'hA5}));

        // Priority: all three toggle on the same edge
        @(posedge clk); #1;
        gap_on = 1; gap_base = grants_seen;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        post(0, 1'b0, 22'h000010, 16'h0000, 2'b11);
        post(1, 1'b1, 22'h000020, 16'h1234, 2'b11);
        post(2, 1'b0, 22'h000030, 16'h0000, 2'b11);
        wait_done(80);

        // Round-robin with client 0 injected mid-stream
        @(posedge clk); #1;
        ctl_fixed = 0;
        gap_base = grants_seen;
        base = acks_seen; injected = 0;
        foreach (exp_q[k]) exp_q.delete(k);
        exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd1);
        exp_q.push_back(2'd0); exp_q.push_back(2'd2); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        post(1, 1'($urandom_range(0, 1)), 22'($urandom_range(0, 4194303)), 16'($urandom), 2'($urandom_range(1, 3)));
        post(2, 1'($urandom_range(0, 1)), 22'($urandom_range(0, 4194303)), 16'($urandom), 2'($urandom_range(1, 3)));
        n1 = 1; n2 = 1;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk); #1;
            if (c_req[1] == c_ack[1] && n1 < 3) begin
                post(1, 1'($urandom_range(0, 1)), 22'($urandom_range(0, 4194303)), 16'($urandom), 2'($urandom_range(1, 3)));
                n1++;
            end
            if (c_req[2] == c_ack[2] && n2 < 3) begin
                post(2, 1'($urandom_range(0, 1)), 22'($urandom_range(0, 4194303)), 16'($urandom), 2'($urandom_range(1, 3)));
                n2++;
            end
            if (!injected && (acks_seen - base) == 2 && busy) begin
                post(0, 1'b0, 22'($urandom_range(0, 4194303)), 16'h0000, 2'b11);
                injected = 1;
            end
            if (exp_q.size() == 0 && c_req == c_ack && !busy) break;
        end
        wait_done(60);
        check("rr_grants", 64'(acks_seen - base), 64'd7);
        gap_on = 0;

        // Hold: client 0 reads 0x1111, then 10 writes from client 1
        @(posedge clk); #1;
        mem[int'(22'h00ABC)] = 16'h1111;
        exp_q.push_back(2'd0);
        post(0, 1'b0, 22'h00ABC, 16'h0000, 2'b11);
        wait_done(40);
        for (int w = 0; w < 10; w++) begin
            exp_q.push_back(2'd1);
            post(1, 1'b1, 22'($urandom_range(0, 4194303)), 16'($urandom), 2'($urandom_range(0, 3)));
            wait_done(40);
        end
        check("hold_rd0", 64'(c_data_read[15:0]), 64'h1111);

        // Reset while BUSY with client 1's write outstanding
        ctl_fixed = 8;
        @(posedge clk); #1;
        exp_q.push_back(2'd1);
        post(1, 1'b1, 22'h2AAAAA, 16'hC3C3, 2'b11);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(posedge clk); #1;
            seen = busy;
        end
        check("rst_wait_busy", 64'(seen), 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("mrst_m_req", 64'(m_req), 64'd0);
        check("mrst_m_we", 64'(m_we), 64'd0);
        check("mrst_m_address", 64'(m_address), 64'd0);
        check("mrst_m_data_write", 64'(m_data_write), 64'd0);
        check("mrst_m_wmask", 64'(m_wmask), 64'd0);
        check("mrst_c_ack", 64'(c_ack), 64'd0);
        check("mrst_c_data_read", 64'(c_data_read), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_grant", 64'(grant), 64'd0);
        check("mrst_fsm_state", 64'(fsm_state), 64'd0);
        c_req = '0;
        ctl_fixed = 3;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // After release: rr_ptr is back at 1, so client 1 beats client 2
        exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        mem[int'(22'h000077)] = 16'h7E57;
        post(1, 1'b0, 22'h000077, 16'h0000, 2'b11);
        post(2, 1'b1, 22'h000078, 16'hA5A5, 2'b01);
        wait_done(60);
        check("post_rst_rd1", 64'(c_data_read[31:16]), 64'h7E57);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Absolute guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
